// File: rtl/spi_nor_flash_responder_pkg.sv
// Shared definitions for the SPI NOR flash responder.
// Holds the opcode set (common with the serial controller), FSM state
// encodings and status register bit positions.
package spi_nor_flash_responder_pkg;

   localparam logic [7:0] OP_RSTEN = 8'h66;
   localparam logic [7:0] OP_RST   = 8'h99;
   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_RDCR  = 8'h35;
   localparam logic [7:0] OP_RDID  = 8'h9F;
   localparam logic [7:0] OP_PP    = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CMD      = 3'd1;
   localparam logic [2:0] ST_ADDR     = 3'd2;
   localparam logic [2:0] ST_DATA_OUT = 3'd3;
   localparam logic [2:0] ST_DATA_IN  = 3'd4;
   localparam logic [2:0] ST_IGNORE   = 3'd5;

   localparam int STAT_WIP = 0;
   localparam int STAT_WEL = 1;

   // RDID byte sequence: ID MSB byte first, then zeros once exhausted.
   function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = id[23:16];
         2'd1:    b = id[15:8];
         2'd2:    b = id[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_nor_flash_responder_pin_sync.sv
// Pin conditioning for the SPI responder.
// Two-flop synchronisers on CS_n, MCLK and MOSI, plus single-cycle
// rise/fall pulses on the synchronised MCLK.
// Ports: clk_i, rst_i (sync, active high), cs_n_i/mclk_i/mosi_i raw pins;
//        cs_n_s, mosi_s synchronised levels; mclk_rise/mclk_fall pulses.
module spi_pin_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic cs_n_i,
   input  logic mclk_i,
   input  logic mosi_i,
   output logic cs_n_s,
   output logic mclk_rise,
   output logic mclk_fall,
   output logic mosi_s
);

   logic [1:0] cs_q;
   logic [2:0] mclk_q;
   logic [1:0] mosi_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cs_q   <= 2'b11;
         mclk_q <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         cs_q   <= {cs_q[0], cs_n_i};
         mclk_q <= {mclk_q[1:0], mclk_i};
         mosi_q <= {mosi_q[0], mosi_i};
      end
   end

   // MOSI goes through the same depth as MCLK so the sampled bit lines up
   // with the rise pulse.
   assign cs_n_s    = cs_q[1];
   assign mosi_s    = mosi_q[1];
   assign mclk_rise =  mclk_q[1] & ~mclk_q[2];
   assign mclk_fall = ~mclk_q[1] &  mclk_q[2];

endmodule

// File: rtl/spi_nor_flash_responder.sv
// Behavioural SPI NOR flash target (SPI mode 0) clocked by crystalClk.
// Ports: crystalClk clock, reset (sync, active high), CS_n/MCLK/MOSI from
//        the controller, MISO back to it, status_out = {6'b0, WEL, WIP},
//        cmd_valid one-cycle opcode strobe, cmd_code last opcode (held).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | deselected, waiting for CS_n low
// ST_CMD      | shifting in the opcode byte
// ST_ADDR     | shifting in the 24-bit address (READ/PP)
// ST_DATA_OUT | shifting out RDSR/RDCR/RDID/READ bytes
// ST_DATA_IN  | programming PP data bytes into memory
// ST_IGNORE   | MISO held low until CS_n rises
module spi_nor_flash_responder
   import spi_nor_flash_responder_pkg::*;
#(
   parameter int          ADDR_BITS   = 8,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4017,
   parameter logic [7:0]  CFG_REG     = 8'h02,
   parameter int          PROG_CYCLES = 64
) (
   input  logic       crystalClk,
   input  logic       reset,
   input  logic       CS_n,
   input  logic       MCLK,
   input  logic       MOSI,
   output logic       MISO,
   output logic [7:0] status_out,
   output logic       cmd_valid,
   output logic [7:0] cmd_code
);

   localparam int TW = $clog2(PROG_CYCLES + 1);
   localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
   localparam logic [ADDR_BITS-1:0] PAGE_MASK = (ADDR_BITS >= 8) ? ADDR_BITS'(8'hFF) : '1;

   logic cs_n_s, mclk_rise, mclk_fall, mosi_s;

   spi_pin_sync u_pin_sync (
      .clk_i     (crystalClk),
      .rst_i     (reset),
      .cs_n_i    (CS_n),
      .mclk_i    (MCLK),
      .mosi_i    (MOSI),
      .cs_n_s    (cs_n_s),
      .mclk_rise (mclk_rise),
      .mclk_fall (mclk_fall),
      .mosi_s    (mosi_s)
   );

   logic [2:0]           state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           tx_q, tx_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 load_q, load_d;
   logic                 miso_q, miso_d;
   logic                 wel_q, wel_d;
   logic                 wip_q, wip_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 armed_q, armed_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic [7:0]           cmd_code_q, cmd_code_d;

   // Stored inverted so the all-zero power-up content of the array reads as
   // erased FFh; reset never touches it.
   logic [7:0]           mem_inv [0:2**ADDR_BITS-1];
   logic                 mem_we;
   logic [7:0]           mem_wdata_inv;

   logic [7:0]           rx_next;
   logic                 byte_done;
   logic [7:0]           status;

   assign rx_next   = {rx_q[6:0], mosi_s};
   assign byte_done = mclk_rise && (bit_cnt_q == 3'd7);
   always_comb begin
      status = 8'h00;
      status[STAT_WEL] = wel_q;
      status[STAT_WIP] = wip_q;
   end

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      rx_d          = rx_q;
      tx_d          = tx_q;
      addr_d        = addr_q;
      load_d        = 1'b0;
      miso_d        = miso_q;
      wel_d         = wel_q;
      wip_d         = wip_q;
      timer_d       = timer_q;
      armed_d       = armed_q;
      cmd_valid_d   = 1'b0;
      cmd_code_d    = cmd_code_q;
      mem_we        = 1'b0;
      mem_wdata_inv = mem_inv[addr_q] | ~rx_next;

      if (wip_q) begin
         if (timer_q == TW'(1)) begin
            wip_d   = 1'b0;
            wel_d   = 1'b0;
            timer_d = '0;
         end else begin
            timer_d = timer_q - TW'(1);
         end
      end

      // Byte reload one cycle after the completing rise, from the registered
      // address; the following MCLK fall is always later than this.
      if (load_q) begin
         case (cmd_code_q)
            OP_RDSR: tx_d = status;
            OP_RDCR: tx_d = CFG_REG;
            OP_RDID: tx_d = jedec_byte(JEDEC_ID, byte_cnt_q);
            default: tx_d = ~mem_inv[addr_q];
         endcase
      end

      if (cs_n_s) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
         if (state_q == ST_DATA_IN && byte_cnt_q != 2'd0) begin
            wip_d   = 1'b1;
            timer_d = TW'(PROG_CYCLES);
         end
      end else begin
         if (mclk_rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         if (mclk_fall && state_q == ST_DATA_OUT) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
               miso_d    = 1'b0;
            end
            ST_CMD: if (byte_done) begin
               cmd_valid_d = 1'b1;
               cmd_code_d  = rx_next;
               armed_d     = 1'b0;
               byte_cnt_d  = '0;
               state_d     = ST_IGNORE;
               if (!wip_q || rx_next == OP_RDSR) begin
                  case (rx_next)
                     OP_RSTEN: armed_d = 1'b1;
                     OP_RST: if (armed_q) begin
                        wel_d   = 1'b0;
                        wip_d   = 1'b0;
                        timer_d = '0;
                     end
                     OP_WREN: wel_d = 1'b1;
                     OP_RDSR, OP_RDCR, OP_RDID: begin
                        state_d = ST_DATA_OUT;
                        load_d  = 1'b1;
                     end
                     OP_READ, OP_PP: state_d = ST_ADDR;
                     default: state_d = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: begin
               if (mclk_rise) addr_d = {addr_q[ADDR_BITS-2:0], mosi_s};
               if (byte_done) begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd2) begin
                     byte_cnt_d = '0;
                     if (cmd_code_q == OP_READ) begin
                        state_d = ST_DATA_OUT;
                        load_d  = 1'b1;
                     end else if (wel_q) begin
                        state_d = ST_DATA_IN;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            ST_DATA_OUT: if (byte_done) begin
               if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
               if (cmd_code_q == OP_READ) addr_d = addr_q + ADDR_ONE;
               load_d = 1'b1;
            end
            ST_DATA_IN: if (byte_done) begin
               mem_we     = 1'b1;
               byte_cnt_d = 2'd1;
               addr_d     = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_ONE) & PAGE_MASK);
            end
            default: miso_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge crystalClk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         addr_q      <= '0;
         load_q      <= 1'b0;
         miso_q      <= 1'b0;
         wel_q       <= 1'b0;
         wip_q       <= 1'b0;
         timer_q     <= '0;
         armed_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         addr_q      <= addr_d;
         load_q      <= load_d;
         miso_q      <= miso_d;
         wel_q       <= wel_d;
         wip_q       <= wip_d;
         timer_q     <= timer_d;
         armed_q     <= armed_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
      end
   end

   always_ff @(posedge crystalClk) begin
      if (mem_we && !reset) mem_inv[addr_q] <= mem_wdata_inv;
   end

   assign MISO       = miso_q;
   assign status_out = status;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_code   = cmd_code_q;

endmodule

// File: tb/tb_spi_nor_flash_responder.sv
module tb_spi_nor_flash_responder;

   localparam int PROG = 800;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       CS_n = 1'b1;
   logic       MCLK = 1'b0;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic [7:0] status_out;
   logic       cmd_valid;
   logic [7:0] cmd_code;

   spi_nor_flash_responder #(.ADDR_BITS(8), .JEDEC_ID(24'hEF4017), .CFG_REG(8'h02),
                             .PROG_CYCLES(PROG)) dut (
      .crystalClk (clk),
      .reset      (reset),
      .CS_n       (CS_n),
      .MCLK       (MCLK),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .status_out (status_out),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: byte array flash plus WEL / WIP / RSTEN-armed flags.
   logic [7:0] m_mem [256];
   logic       m_wel = 1'b0;
   logic       m_wip = 1'b0;
   logic       m_armed = 1'b0;

   logic [7:0] wr_buf [8];
   logic [7:0] rd_buf [8];

   int cv_cnt = 0;
   always @(posedge clk) if (cmd_valid === 1'b1) cv_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xbits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nb; i++) begin
         MOSI = tx[7-i];
         tick(4);
         rx[7-i] = MISO;
         MCLK = 1'b1;
         tick(4);
         MCLK = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      xbits(tx, 8, rx);
   endtask

   task automatic cs_low();
      CS_n = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      tick(2);
      CS_n = 1'b1;
      tick(6);
   endtask

   task automatic model_cmd(input logic [7:0] op);
      if (!m_wip) begin
         if (op == 8'h99 && m_armed) m_wel = 1'b0;
         if (op == 8'h06) m_wel = 1'b1;
      end
      m_armed = (op == 8'h66) && !m_wip;
   endtask

   task automatic send_cmd(input logic [7:0] op);
      logic [7:0] r;
      cs_low();
      xfer(op, r);
      cs_high();
      model_cmd(op);
   endtask

   task automatic do_rdsr(output logic [7:0] s);
      logic [7:0] r;
      cs_low();
      xfer(8'h05, r);
      xfer(8'h00, s);
      cs_high();
      m_armed = 1'b0;
   endtask

   task automatic send_addr(input logic [7:0] op, input int a);
      logic [7:0] r;
      xfer(op, r);
      xfer(8'($urandom), r);
      xfer(8'($urandom), r);
      xfer(8'(a), r);
   endtask

   task automatic do_read(input int a, input int n);
      cs_low();
      send_addr(8'h03, a);
      for (int i = 0; i < n; i++) xfer(8'h00, rd_buf[i]);
      cs_high();
      m_armed = 1'b0;
   endtask

   task automatic do_pp(input int a, input int n);
      logic [7:0] r;
      cs_low();
      send_addr(8'h02, a);
      for (int i = 0; i < n; i++) xfer(wr_buf[i], r);
      cs_high();
      if (m_wel && !m_wip && n > 0) begin
         for (int i = 0; i < n; i++) m_mem[8'(a + i)] = m_mem[8'(a + i)] & wr_buf[i];
         m_wip = 1'b1;
      end
      m_armed = 1'b0;
   endtask

   task automatic prog_check(input string tag);
      logic [7:0] s;
      do_rdsr(s);
      check({tag, "_rdsr_busy"}, s, {6'b0, m_wel, m_wip});
      tick(PROG + 20);
      m_wip = 1'b0;
      m_wel = 1'b0;
      do_rdsr(s);
      check({tag, "_rdsr_done"}, s, {6'b0, m_wel, m_wip});
   endtask

   logic [7:0] s, r;
   int cv0, a, n, ra;

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
      tick(5);
      reset = 1'b0;
      tick(3);
      check("rst_miso", MISO, 0);
      check("rst_status", status_out, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd_code", cmd_code, 0);

      // RDID
      cv0 = cv_cnt;
      cs_low();
      xfer(8'h9F, r);
      for (int i = 0; i < 4; i++) xfer(8'h00, rd_buf[i]);
      cs_high();
      check("rdid_b0", rd_buf[0], 8'hEF);
      check("rdid_b1", rd_buf[1], 8'h40);
      check("rdid_b2", rd_buf[2], 8'h17);
      check("rdid_b3", rd_buf[3], 8'h00);
      check("rdid_cv_count", cv_cnt - cv0, 1);
      check("rdid_cmd_code", cmd_code, 8'h9F);

      // Status / config
      do_rdsr(s);
      check("rdsr_reset", s, {6'b0, m_wel, m_wip});
      send_cmd(8'h06);
      do_rdsr(s);
      check("rdsr_wren", s, {6'b0, m_wel, m_wip});
      check("status_out_wren", status_out, 8'h02);
      cs_low();
      xfer(8'h35, r);
      xfer(8'h00, s);
      cs_high();
      check("rdcr", s, 8'h02);

      // Program then read back, including READ while busy
      wr_buf[0] = 8'h05;
      do_pp(32'hA0, 1);
      do_rdsr(s);
      check("pp_rdsr_busy", s, {6'b0, m_wel, m_wip});
      do_read(32'hA0, 1);
      check("read_during_wip", rd_buf[0], 8'h00);
      tick(PROG + 20);
      m_wip = 1'b0;
      m_wel = 1'b0;
      do_rdsr(s);
      check("pp_rdsr_done", s, {6'b0, m_wel, m_wip});
      do_read(32'hA0, 2);
      check("read_a0", rd_buf[0], m_mem[8'hA0]);
      check("read_a1", rd_buf[1], m_mem[8'hA1]);

      // Protection: PP without WREN is ignored
      wr_buf[0] = 8'h00;
      do_pp(32'h10, 1);
      do_read(32'h10, 1);
      check("pp_no_wel", rd_buf[0], 8'hFF);
      do_rdsr(s);
      check("pp_no_wel_status", s, 8'h00);

      // AND semantics
      send_cmd(8'h06);
      wr_buf[0] = 8'h0F;
      do_pp(32'hA0, 1);
      prog_check("and");
      do_read(32'hA0, 1);
      check("and_read", rd_buf[0], 8'h05);

      // Address wrap on READ and page wrap on PP
      do_read(32'hFF, 2);
      check("rd_wrap_ff", rd_buf[0], m_mem[8'hFF]);
      check("rd_wrap_00", rd_buf[1], m_mem[8'h00]);
      send_cmd(8'h06);
      wr_buf[0] = 8'h3C;
      wr_buf[1] = 8'h5A;
      do_pp(32'hFF, 2);
      prog_check("ppwrap");
      do_read(32'hFF, 2);
      check("pp_wrap_ff", rd_buf[0], 8'h3C);
      check("pp_wrap_00", rd_buf[1], 8'h5A);

      // Partial final byte discarded
      send_cmd(8'h06);
      cs_low();
      send_addr(8'h02, 32'h40);
      xfer(8'h00, r);
      xbits(8'h00, 4, r);
      cs_high();
      m_mem[8'h40] = 8'h00;
      m_wip = 1'b1;
      prog_check("partial");
      do_read(32'h40, 2);
      check("partial_b0", rd_buf[0], 8'h00);
      check("partial_b1", rd_buf[1], 8'hFF);

      // PP with no data keeps WEL
      send_cmd(8'h06);
      do_pp(32'h20, 0);
      do_rdsr(s);
      check("pp_zero_wel", s, {6'b0, m_wel, m_wip});

      // Abort after 12 address bits, then RDID
      cs_low();
      xfer(8'h03, r);
      xfer(8'h00, r);
      xbits(8'h00, 4, r);
      cs_high();
      cs_low();
      xfer(8'h9F, r);
      for (int i = 0; i < 3; i++) xfer(8'h00, rd_buf[i]);
      cs_high();
      check("abort_rdid0", rd_buf[0], 8'hEF);
      check("abort_rdid1", rd_buf[1], 8'h40);
      check("abort_rdid2", rd_buf[2], 8'h17);
      m_armed = 1'b0;

      // Reset command arming
      send_cmd(8'h99);
      do_rdsr(s);
      check("rst_alone", s, {6'b0, m_wel, m_wip});
      send_cmd(8'h66);
      send_cmd(8'h99);
      do_rdsr(s);
      check("rsten_rst", s, {6'b0, m_wel, m_wip});
      send_cmd(8'h66);
      send_cmd(8'h06);
      send_cmd(8'h99);
      do_rdsr(s);
      check("rsten_wren_rst", s, {6'b0, m_wel, m_wip});
      send_cmd(8'h66);
      send_cmd(8'h99);

      // Randomised program / read-back against the model
      for (int k = 0; k < 6; k++) begin
         a = int'($urandom_range(0, 255));
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
         if ($urandom_range(0, 3) != 0) send_cmd(8'h06);
         if (m_wel) begin
            do_pp(a, n);
            prog_check("rand");
         end else begin
            do_pp(a, n);
            do_rdsr(s);
            check("rand_nowel_status", s, {6'b0, m_wel, m_wip});
         end
         ra = int'($urandom_range(0, 255));
         if (k[0]) ra = a;
         do_read(ra, n + 1);
         for (int i = 0; i <= n; i++) check("rand_read", rd_buf[i], m_mem[8'(ra + i)]);
      end

      // Reset asserted mid-READ
      a = 0;
      for (int i = 255; i >= 0; i--) if (m_mem[i][7]) a = i;
      cs_low();
      send_addr(8'h03, a);
      tick(4);
      check("midread_miso_bit7", MISO, m_mem[8'(a)][7]);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midread_reset_miso", MISO, 0);
      CS_n = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
